// File: rtl/fc_credit_gate.sv
// fc_credit_gate: transmit flow-control gate between the pending TLP buffer
// and the link layer. It holds the receiver's advertised credit limits for
// posted, non-posted and completion traffic and checks the head TLP against
// them. When the TLP fits, it pulses send_signal to release it. It also keeps
// its own credits-consumed counters, which wrap at the PCIe field widths.
module fc_credit_gate #(
    parameter int HDR_W   = 8,
    parameter int DATA_W  = 12,
    parameter int DCRED_W = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fc_init_valid,
    input  logic               fc_init_done,
    input  logic               fc_upd_valid,
    input  logic [1:0]         fc_class,
    input  logic [HDR_W-1:0]   fc_hdr,
    input  logic [DATA_W-1:0]  fc_data,
    input  logic               tlp_valid,
    input  logic [1:0]         tlp_class,
    input  logic [DCRED_W-1:0] tlp_data_credits,
    output logic               send_signal,
    output logic               tx_blocked,
    output logic               err_bad_class,
    output logic [HDR_W-1:0]   ph_cc,
    output logic [HDR_W-1:0]   nph_cc,
    output logic [HDR_W-1:0]   ch_cc,
    output logic [DATA_W-1:0]  pd_cc,
    output logic [DATA_W-1:0]  npd_cc,
    output logic [DATA_W-1:0]  cd_cc
);

    // Classes 0..2 are P, NP and Cpl; class 3 is reserved.
    localparam int NUM_CLASSES = 3;

    // Half of each field's modulus. A remaining-credit distance at or below
    // this value means "fits"; a larger value means the subtraction wrapped
    // negative.
    localparam logic [HDR_W-1:0]  HDR_HALF  = {1'b1, {(HDR_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] DATA_HALF = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CHECK,
        ST_GRANT,
        ST_GAP,
        ST_BLOCKED
    } state_t;

    state_t state;

    // Receiver limits and infinite-credit flags, one entry per class.
    logic [NUM_CLASSES-1:0][HDR_W-1:0]  lim_hdr;
    logic [NUM_CLASSES-1:0][DATA_W-1:0] lim_data;
    logic [NUM_CLASSES-1:0]             inf_hdr;
    logic [NUM_CLASSES-1:0]             inf_data;

    // Local credits-consumed counters, one entry per class.
    logic [NUM_CLASSES-1:0][HDR_W-1:0]  cc_hdr;
    logic [NUM_CLASSES-1:0][DATA_W-1:0] cc_data;

    // Head TLP attributes, captured when it is accepted from IDLE.
    logic [1:0]         cls_q;
    logic [DCRED_W-1:0] dcred_q;

    // Check datapath for the captured class.
    logic [HDR_W-1:0]  sel_lim_hdr;
    logic [DATA_W-1:0] sel_lim_data;
    logic [HDR_W-1:0]  sel_cc_hdr;
    logic [DATA_W-1:0] sel_cc_data;
    logic              sel_inf_hdr;
    logic              sel_inf_data;
    logic [HDR_W-1:0]  hdr_gap;
    logic [DATA_W-1:0] data_gap;
    logic [DATA_W-1:0] data_req;
    logic              hdr_ok;
    logic              data_ok;
    logic              credit_ok;
    logic              bad_class;

    assign bad_class = (cls_q == 2'b11);
    assign data_req  = DATA_W'(dcred_q);

    // Select the captured class's limits and counters, then test both fields.
    // NOTE: every always_comb output gets a default first, so no path can leave
    // a signal unassigned and infer a latch.
    always_comb begin
        sel_lim_hdr  = '0;
        sel_lim_data = '0;
        sel_cc_hdr   = '0;
        sel_cc_data  = '0;
        sel_inf_hdr  = 1'b0;
        sel_inf_data = 1'b0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (cls_q == 2'(c)) begin
                sel_lim_hdr  = lim_hdr[c];
                sel_lim_data = lim_data[c];
                sel_cc_hdr   = cc_hdr[c];
                sel_cc_data  = cc_data[c];
                sel_inf_hdr  = inf_hdr[c];
                sel_inf_data = inf_data[c];
            end
        end
        hdr_gap   = sel_lim_hdr - (sel_cc_hdr + HDR_W'(1));
        data_gap  = sel_lim_data - (sel_cc_data + data_req);
        hdr_ok    = sel_inf_hdr || (hdr_gap <= HDR_HALF);
        data_ok   = (dcred_q == '0) || sel_inf_data || (data_gap <= DATA_HALF);
        credit_ok = hdr_ok && data_ok;
    end

    // Limit registers: InitFC loads during INIT; UpdateFC overwrites afterwards
    // unless the field was advertised as infinite.
    // NOTE: the limit arrays are reset like any other state. They are small
    // flops, not RAM, and a stale limit after reset would grant wrongly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lim_hdr  <= '0;
            lim_data <= '0;
            inf_hdr  <= '0;
            inf_data <= '0;
        end else begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (fc_class == 2'(c)) begin
                    if (state == ST_INIT && fc_init_valid) begin
                        lim_hdr[c]  <= fc_hdr;
                        lim_data[c] <= fc_data;
                        if (fc_hdr == '0) begin
                            inf_hdr[c] <= 1'b1;
                        end
                        if (fc_data == '0) begin
                            inf_data[c] <= 1'b1;
                        end
                    end else if (state != ST_INIT && fc_upd_valid) begin
                        if (!inf_hdr[c]) begin
                            lim_hdr[c] <= fc_hdr;
                        end
                        if (!inf_data[c]) begin
                            lim_data[c] <= fc_data;
                        end
                    end
                end
            end
        end
    end

    // Gate FSM: sequences accept, check, grant and gap, drives the registered
    // status outputs, and advances the consumed counters on each grant.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_INIT;
            cls_q         <= '0;
            dcred_q       <= '0;
            send_signal   <= 1'b0;
            tx_blocked    <= 1'b0;
            err_bad_class <= 1'b0;
            cc_hdr        <= '0;
            cc_data       <= '0;
        end else begin
            send_signal   <= 1'b0;
            err_bad_class <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (fc_init_done) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (tlp_valid) begin
                        cls_q   <= tlp_class;
                        dcred_q <= tlp_data_credits;
                        state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (bad_class) begin
                        err_bad_class <= 1'b1;
                        state         <= ST_GAP;
                    end else if (credit_ok) begin
                        send_signal <= 1'b1;
                        state       <= ST_GRANT;
                    end else begin
                        tx_blocked <= 1'b1;
                        state      <= ST_BLOCKED;
                    end
                end
                ST_BLOCKED: begin
                    if (credit_ok) begin
                        send_signal <= 1'b1;
                        tx_blocked  <= 1'b0;
                        state       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    for (int c = 0; c < NUM_CLASSES; c++) begin
                        if (cls_q == 2'(c)) begin
                            cc_hdr[c]  <= cc_hdr[c] + HDR_W'(1);
                            cc_data[c] <= cc_data[c] + data_req;
                        end
                    end
                    state <= ST_GAP;
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    assign ph_cc  = cc_hdr[0];
    assign nph_cc = cc_hdr[1];
    assign ch_cc  = cc_hdr[2];
    assign pd_cc  = cc_data[0];
    assign npd_cc = cc_data[1];
    assign cd_cc  = cc_data[2];

endmodule

// File: tb/tb_fc_credit_gate.sv
// Directed testbench for fc_credit_gate. Inputs change and outputs are sampled
// on the falling edge; the DUT acts on the rising edge.
module tb_fc_credit_gate;

    localparam int HDR_W   = 8;
    localparam int DATA_W  = 12;
    localparam int DCRED_W = 9;

    localparam logic [1:0] CLS_P   = 2'b00;
    localparam logic [1:0] CLS_NP  = 2'b01;
    localparam logic [1:0] CLS_RSV = 2'b11;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               fc_init_valid;
    logic               fc_init_done;
    logic               fc_upd_valid;
    logic [1:0]         fc_class;
    logic [HDR_W-1:0]   fc_hdr;
    logic [DATA_W-1:0]  fc_data;
    logic               tlp_valid;
    logic [1:0]         tlp_class;
    logic [DCRED_W-1:0] tlp_data_credits;
    logic               send_signal;
    logic               tx_blocked;
    logic               err_bad_class;
    logic [HDR_W-1:0]   ph_cc, nph_cc, ch_cc;
    logic [DATA_W-1:0]  pd_cc, npd_cc, cd_cc;

    int n_checks = 0;
    int n_pass   = 0;
    int blocked_seen = 0;

    fc_credit_gate #(
        .HDR_W   (HDR_W),
        .DATA_W  (DATA_W),
        .DCRED_W (DCRED_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fc_init_valid    (fc_init_valid),
        .fc_init_done     (fc_init_done),
        .fc_upd_valid     (fc_upd_valid),
        .fc_class         (fc_class),
        .fc_hdr           (fc_hdr),
        .fc_data          (fc_data),
        .tlp_valid        (tlp_valid),
        .tlp_class        (tlp_class),
        .tlp_data_credits (tlp_data_credits),
        .send_signal      (send_signal),
        .tx_blocked       (tx_blocked),
        .err_bad_class    (err_bad_class),
        .ph_cc            (ph_cc),
        .nph_cc           (nph_cc),
        .ch_cc            (ch_cc),
        .pd_cc            (pd_cc),
        .npd_cc           (npd_cc),
        .cd_cc            (cd_cc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One InitFC beat, optionally with fc_init_done in the same cycle.
    task automatic fc_init(input logic [1:0] cls, input int unsigned hdr,
                           input int unsigned data, input logic done);
        fc_init_valid = 1'b1;
        fc_init_done  = done;
        fc_class      = cls;
        fc_hdr        = HDR_W'(hdr);
        fc_data       = DATA_W'(data);
        @(negedge clk);
        fc_init_valid = 1'b0;
        fc_init_done  = 1'b0;
    endtask

    // One UpdateFC beat.
    task automatic fc_update(input logic [1:0] cls, input int unsigned hdr,
                             input int unsigned data);
        fc_upd_valid = 1'b1;
        fc_class     = cls;
        fc_hdr       = HDR_W'(hdr);
        fc_data      = DATA_W'(data);
        @(negedge clk);
        fc_upd_valid = 1'b0;
    endtask

    // Present one TLP from IDLE and pop it on send_signal. lat is the number
    // of cycles from presentation to send_signal, or -1 if it never came.
    task automatic send_tlp(input logic [1:0] cls, input int unsigned cred, output int lat);
        tlp_valid        = 1'b1;
        tlp_class        = cls;
        tlp_data_credits = DCRED_W'(cred);
        lat = -1;
        for (int i = 1; i <= 8 && lat < 0; i++) begin
            @(negedge clk);
            if (tx_blocked) blocked_seen++;
            if (send_signal) lat = i;
        end
        tlp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int nsend;
        int nerr;
        int first_idx;
        int last_idx;
        int bad_lat;
        int model_cc;

        rst_n            = 1'b0;
        fc_init_valid    = 1'b0;
        fc_init_done     = 1'b0;
        fc_upd_valid     = 1'b0;
        fc_class         = 2'b00;
        fc_hdr           = '0;
        fc_data          = '0;
        tlp_valid        = 1'b0;
        tlp_class        = 2'b00;
        tlp_data_credits = '0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state.
        check("rst_send", send_signal, 0);
        check("rst_blocked", tx_blocked, 0);
        check("rst_err", err_bad_class, 0);
        check("rst_ph_cc", ph_cc, 0);
        check("rst_pd_cc", pd_cc, 0);

        // Test 1: PH=4, PD=16; stream of posted TLPs with 2 data credits.
        fc_init(CLS_P, 4, 16, 1'b0);
        fc_init(CLS_NP, 8, 64, 1'b0);
        fc_init(2'b10, 8, 64, 1'b1);
        tlp_valid        = 1'b1;
        tlp_class        = CLS_P;
        tlp_data_credits = 9'd2;
        nsend = 0;
        first_idx = -1;
        last_idx = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (send_signal) begin
                nsend++;
                if (first_idx < 0) first_idx = i;
                last_idx = i;
            end
        end
        check("t1_sends", nsend, 4);
        check("t1_first_latency", first_idx, 2);
        check("t1_last_pulse", last_idx, 14);
        check("t1_blocked", tx_blocked, 1);
        check("t1_ph_cc", ph_cc, 4);
        check("t1_pd_cc", pd_cc, 8);

        // Test 2: UpdateFC P hdr=5 releases the blocked TLP one cycle later.
        fc_update(CLS_P, 5, 16);
        check("t2_no_send_yet", send_signal, 0);
        check("t2_still_blocked", tx_blocked, 1);
        @(negedge clk);
        check("t2_send", send_signal, 1);
        check("t2_unblocked", tx_blocked, 0);
        tlp_valid = 1'b0;
        @(negedge clk);
        check("t2_ph_cc", ph_cc, 5);
        check("t2_pd_cc", pd_cc, 10);
        @(negedge clk);

        // Test 3: walk ph_cc to 255 with the limit tracking, then wrap.
        model_cc = 5;
        bad_lat = 0;
        while (model_cc != 255) begin
            fc_update(CLS_P, (model_cc + 1) % 256, 16);
            send_tlp(CLS_P, 0, lat);
            if (lat != 2) bad_lat++;
            model_cc++;
        end
        check("t3_bad_latency", bad_lat, 0);
        check("t3_ph_cc_255", ph_cc, 255);
        check("t3_pd_cc", pd_cc, 10);
        fc_update(CLS_P, 0, 16);
        send_tlp(CLS_P, 0, lat);
        check("t3_wrap_latency", lat, 2);
        check("t3_ph_cc_wrap", ph_cc, 0);

        // Test 5: reserved class pulses the error and consumes nothing.
        tlp_valid = 1'b1;
        tlp_class = CLS_RSV;
        tlp_data_credits = 9'd4;
        @(negedge clk);
        tlp_valid = 1'b0;
        nsend = 0;
        nerr = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (send_signal) nsend++;
            if (err_bad_class) nerr++;
        end
        check("t5_err_pulses", nerr, 1);
        check("t5_sends", nsend, 0);
        check("t5_ph_cc", ph_cc, 0);
        check("t5_pd_cc", pd_cc, 10);
        check("t5_nph_cc", nph_cc, 0);

        // Test 6: block a P TLP (limit 0, cc 0), then reset for one cycle.
        tlp_valid = 1'b1;
        tlp_class = CLS_P;
        tlp_data_credits = 9'd0;
        nsend = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (send_signal) nsend++;
        end
        check("t6_pre_sends", nsend, 0);
        check("t6_pre_blocked", tx_blocked, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_rst_blocked", tx_blocked, 0);
        check("t6_rst_send", send_signal, 0);
        check("t6_rst_err", err_bad_class, 0);
        check("t6_rst_ph_cc", ph_cc, 0);
        check("t6_rst_pd_cc", pd_cc, 0);
        nsend = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (send_signal) nsend++;
        end
        fc_init(CLS_P, 10, 100, 1'b0);
        if (send_signal) nsend++;
        // UpdateFC during INIT must not zero the P limit.
        fc_update(CLS_P, 0, 0);
        if (send_signal) nsend++;
        check("t6_init_sends", nsend, 0);
        // NP advertised infinite, with done in the same cycle.
        fc_init(CLS_NP, 0, 0, 1'b1);
        lat = -1;
        for (int i = 1; i <= 8 && lat < 0; i++) begin
            @(negedge clk);
            if (send_signal) lat = i;
        end
        tlp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_post_init_latency", lat, 2);
        check("t6_ph_cc", ph_cc, 1);

        // Test 4: infinite NP credits, 300 TLPs of 1 data credit.
        blocked_seen = 0;
        bad_lat = 0;
        for (int i = 0; i < 300; i++) begin
            send_tlp(CLS_NP, 1, lat);
            if (lat != 2) bad_lat++;
        end
        check("t4_bad_latency", bad_lat, 0);
        check("t4_blocked_seen", blocked_seen, 0);
        check("t4_nph_cc", nph_cc, 44);
        check("t4_npd_cc", npd_cc, 300);
        fc_update(CLS_NP, 1, 1);
        send_tlp(CLS_NP, 1, lat);
        check("t4_upd_ignored_latency", lat, 2);
        check("t4_nph_cc_after", nph_cc, 45);
        check("t4_npd_cc_after", npd_cc, 301);
        check("t4_ch_cc", ch_cc, 0);
        check("t4_cd_cc", cd_cc, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
